// File: rtl/alu_if.sv
// Handshake bundle between an operation source and alu_pipe.
// The master modport is the source/consumer side and the slave modport is the ALU side.
interface alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [4:0]      rd_addr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd_addr;
  logic            busy;

  modport master (
    output in_valid, op, in1, in2, rd_addr, out_ready,
    input  in_ready, out_valid, out_data, out_rd_addr, busy
  );

  modport slave (
    input  in_valid, op, in1, in2, rd_addr, out_ready,
    output in_ready, out_valid, out_data, out_rd_addr, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with a valid/ready result register.
// Shifts are either one-cycle barrel shifts or serial 1 bit/cycle shifts.
module alu_pipe #(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  alu_if.slave       io,
  output logic [1:0] dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid must then hold its payload until that edge. in_ready
  // depends combinationally on out_ready so HOLD can retire one result and
  // accept the next operation in the same cycle.

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] sh_val_q, sh_val_d;
  logic [1:0]      sh_op_q, sh_op_d;

  logic            accept;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shift1;

  assign io.in_ready = rst && (state_q != S_SHIFT) && (!out_valid_q || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;
  assign shamt       = io.in2[SHW-1:0];
  assign is_shift    = (io.op == 4'd5) || (io.op == 4'd6) || (io.op == 4'd7);

  always_comb begin
    alu_res = '0;
    case (io.op)
      4'd0:    alu_res = io.in1 + io.in2;
      4'd1:    alu_res = io.in1 - io.in2;
      4'd2:    alu_res = io.in1 ^ io.in2;
      4'd3:    alu_res = io.in1 | io.in2;
      4'd4:    alu_res = io.in1 & io.in2;
      4'd5:    alu_res = io.in1 << shamt;
      4'd6:    alu_res = io.in1 >> shamt;
      4'd7:    alu_res = $unsigned($signed(io.in1) >>> shamt);
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(io.in1) < $signed(io.in2)};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, io.in1 < io.in2};
      default: alu_res = '0;
    endcase
  end

  // sh_op_q holds op[1:0]: 01 SLL, 10 SRL, 11 SRA.
  always_comb begin
    shift1 = '0;
    case (sh_op_q)
      2'b01:   shift1 = sh_val_q << 1;
      2'b10:   shift1 = sh_val_q >> 1;
      default: shift1 = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_valid_d = out_valid_q;
    busy_d      = 1'b0;
    cnt_d       = cnt_q;
    sh_val_d    = sh_val_q;
    sh_op_d     = sh_op_q;
    case (state_q)
      S_SHIFT: begin
        sh_val_d = shift1;
        cnt_d    = cnt_q - SHW'(1);
        busy_d   = 1'b1;
        if (cnt_q == SHW'(1)) begin
          out_data_d  = shift1;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end
      end
      default: begin
        if (state_q == S_HOLD && io.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          out_rd_d = io.rd_addr;
          if (SERIAL_SHIFT != 0 && is_shift && shamt != '0) begin
            state_d     = S_SHIFT;
            busy_d      = 1'b1;
            sh_val_d    = io.in1;
            sh_op_d     = io.op[1:0];
            cnt_d       = shamt;
            out_valid_d = 1'b0;
          end else begin
            state_d     = S_HOLD;
            out_data_d  = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      sh_val_q    <= '0;
      sh_op_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      sh_val_q    <= sh_val_d;
      sh_op_q     <= sh_op_d;
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_data    = out_data_q;
  assign io.out_rd_addr = out_rd_q;
  assign io.busy        = busy_q;
  assign dbg_state      = state_q;
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SERIAL_SHIFT, default 0; 0 = single-cycle barrel shift, 1 = iterative shift at 1 bit/cycle.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-low (rst=0 resets).
REQ-005 in_valid  input  1  operation offered this cycle.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 op  input  4  operation code, per REQ-013.
REQ-008 in1, in2  input  XLEN each  operands.
REQ-009 rd_addr  input  5  destination tag, carried with the result.
REQ-010 out_valid  output  1  result held on out_data.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  XLEN; out_rd_addr  output  5; busy  output  1 (high while in SHIFT state).

Function
REQ-013 Op codes: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU; codes 10-15 produce result 0 with normal handshake.
REQ-014 Accept occurs when in_valid && in_ready; op, operands and rd_addr are captured on accept.
REQ-015 ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
REQ-016 SLT/SLTU result is 1 or 0, zero-extended to XLEN; SLTU compares unsigned.
REQ-017 Shift amount = in2[log2(XLEN)-1:0]; upper bits of in2 are ignored; SRA replicates in1[XLEN-1].
REQ-018 FSM states: IDLE, SHIFT, HOLD; SHIFT is reachable only when SERIAL_SHIFT=1.
REQ-019 IDLE: on accept of a non-shift op (or any op when SERIAL_SHIFT=0, or a shift with shamt=0), the result is registered and the FSM goes to HOLD with out_valid=1 the next cycle (latency 1).
REQ-020 IDLE: on accept of a shift with shamt>0 and SERIAL_SHIFT=1, load the operand and a down-counter = shamt, go to SHIFT.
REQ-021 SHIFT: shift by one bit per cycle and decrement the counter; when the counter reaches 1, the final shift result is registered and the FSM goes to HOLD (latency = shamt cycles).
REQ-022 HOLD: out_data, out_rd_addr and out_valid are stable until out_ready; on out_ready without a new accept, go to IDLE.
REQ-023 in_ready = rst && state!=SHIFT && (!out_valid || out_ready); a new accept in HOLD with out_ready=1 performs REQ-019/020 in the same cycle (back-to-back, one result per cycle).
REQ-024 in_valid while in_ready=0 is ignored; the source holds it.
REQ-025 busy=1 exactly while state==SHIFT.
REQ-026 out_valid never drops without out_ready; no result is lost or duplicated.

Reset
REQ-027 While rst=0: state=IDLE, out_valid=0, out_data=0, out_rd_addr=0, busy=0, in_ready=0, shift counter=0.
REQ-028 Reset during SHIFT or HOLD discards the in-flight operation; no result appears after reset release.
REQ-029 in_ready=1 in the first cycle after rst returns to 1.

Verification
REQ-030 XLEN=32, ADD in1=0xFFFFFFFF in2=1 rd=5 -> next cycle out_valid=1, out_data=0, out_rd_addr=5.
REQ-031 SUB 3-5 -> 0xFFFFFFFE; SLT in1=0xFFFFFFFF in2=1 -> 1; SLTU same operands -> 0; op 12 -> 0.
REQ-032 SERIAL_SHIFT=1, SRA in1=0x80000000 in2=0x24 (shamt 4) -> busy for 4 cycles, in_ready=0 throughout, then out_data=0xF8000000; shamt 0 -> 1-cycle latency, out_data=in1.
REQ-033 out_ready=0 for 3 cycles in HOLD with in_valid=1 -> out_data stable, no accept; then out_ready=1 -> accept the same cycle, 10 back-to-back ADDs give 10 results in order, 1 per cycle.
REQ-034 rst=0 asserted mid-SHIFT (SLL shamt 20, cycle 7) -> next cycle out_valid=0, busy=0; after release no stale result; next ADD 1+1 -> 2.
REQ-035 XLEN=64, SLL in1=1 in2=63 -> 0x8000000000000000; SRL in2=0x40 -> shamt 0, out_data=in1.
